thcomp_peak_detect: RTL and testbench



---
 rtl/thcomp_peak_detect.sv | 136 +++++++++++++
 tb/tb_thcomp_peak_detect.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/thcomp_peak_detect.sv
// Threshold-compare / peak tracker: finds the first magnitude above a frozen threshold,
// follows the local maximum and writes a packed {detect, peak index} result word.
module thcomp_peak_detect #(
  parameter int MSB      = 15,
  parameter int PEAK_WIN = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         corr_valid,
  input  logic [MSB:0] corr_mag,
  input  logic [MSB:0] thcompregs_thcomp_reg_data_out1,
  output logic         thcomptop_thcompregs_we0,
  output logic [MSB:0] thcomptop_thcompregs_reg_data_in0,
  output logic [MSB:0] peak_mag,
  output logic         busy,
  output logic         done
);

  localparam int CW = MSB;
  localparam logic [CW-1:0] LAST_IDX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK, REPORT} state_t;

  state_t        state_q, state_d;
  logic [MSB:0]  th_q, th_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] run_q, run_d;
  logic [MSB:0]  pk_q, pk_d;
  logic [CW-1:0] pidx_q, pidx_d;
  logic [MSB:0]  res_q, res_d;
  logic [MSB:0]  pko_q, pko_d;
  logic          last, upd, close;

  always_comb begin
    state_d = state_q;
    th_d    = th_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    pk_d    = pk_q;
    pidx_d  = pidx_q;
    res_d   = res_q;
    pko_d   = pko_q;
    last    = (cnt_q == LAST_IDX);
    upd     = 1'b0;
    close   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          th_d    = thcompregs_thcomp_reg_data_out1;
          cnt_d   = '0;
          run_d   = '0;
          pk_d    = '0;
          pidx_d  = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (corr_valid) begin
          if (corr_mag > th_q) begin
            pk_d   = corr_mag;
            pidx_d = cnt_q;
            run_d  = '0;
            // A crossing on the final allowed sample is still a detection.
            if (last) begin
              res_d   = {1'b1, cnt_q};
              pko_d   = corr_mag;
              state_d = REPORT;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = TRACK;
            end
          end else if (last) begin
            res_d   = {1'b0, {CW{1'b1}}};
            pko_d   = '0;
            state_d = REPORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRACK: begin
        if (corr_valid) begin
          upd = (corr_mag > pk_q);
          if (upd) begin
            pk_d   = corr_mag;
            pidx_d = cnt_q;
            run_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
          close = (!upd && (int'(run_q) + 1 >= PEAK_WIN - 1)) || last;
          if (close) begin
            res_d   = {1'b1, upd ? cnt_q : pidx_q};
            pko_d   = upd ? corr_mag : pk_q;
            state_d = REPORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      th_q    <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      pk_q    <= '0;
      pidx_q  <= '0;
      res_q   <= '0;
      pko_q   <= '0;
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      pk_q    <= pk_d;
      pidx_q  <= pidx_d;
      res_q   <= res_d;
      pko_q   <= pko_d;
    end
  end

  assign thcomptop_thcompregs_we0          = (state_q == REPORT);
  assign done                              = (state_q == REPORT);
  assign busy                              = (state_q != IDLE);
  assign thcomptop_thcompregs_reg_data_in0 = res_q;
  assign peak_mag                          = pko_q;

endmodule

// File: tb/tb_thcomp_peak_detect.sv
// Directed bench for thcomp_peak_detect: table of streams with hand-computed results
// plus hand sequences for reset mid-search and restart right after a report.
module tb_thcomp_peak_detect;
  localparam int MSB = 15, PEAK_WIN = 4, TIMEOUT = 64;

  logic        clk = 0;
  logic        rst, start, corr_valid;
  logic [15:0] corr_mag, thr;
  logic        we0, busy, done;
  logic [15:0] data, pkm;

  int checks = 0, failures = 0;

  thcomp_peak_detect #(.MSB(MSB), .PEAK_WIN(PEAK_WIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .corr_valid(corr_valid), .corr_mag(corr_mag),
    .thcompregs_thcomp_reg_data_out1(thr),
    .thcomptop_thcompregs_we0(we0), .thcomptop_thcompregs_reg_data_in0(data),
    .peak_mag(pkm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int th, pre, fill, n, gap, sa, thc, thv, ec, ed, ep;
    int mag[8];
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int th, int pre, int fill, int n, int gap, int sa,
                              int thc, int thv, int ec, int ed, int ep);
    vec_t v;
    v.th = th; v.pre = pre; v.fill = fill; v.n = n; v.gap = gap; v.sa = sa;
    v.thc = thc; v.thv = thv; v.ec = ec; v.ed = ed; v.ep = ep;
    v.mag = '{default: 0};
    return v;
  endfunction

  // Start at c=0, sample i driven at negedge c=i+1 (c=2i+1 with gaps); we0 seen at negedge.
  task automatic run_row(input vec_t v, input int r);
    int c = 0, idx = 0;
    bit seen = 0;
    thr = 16'(v.th); start = 1; corr_valid = 0;
    while (!seen && c < v.ec + 20) begin
      @(negedge clk);
      c++;
      start = (c == v.sa);
      if (c == 1) chk($sformatf("r%0d_busy_start", r), 32'(busy), 1);
      if (v.thc == c) thr = 16'(v.thv);
      if (we0) begin
        seen = 1;
        corr_valid = 0;
        chk($sformatf("r%0d_cycle", r), c, v.ec);
        chk($sformatf("r%0d_data", r), 32'(data), v.ed);
        chk($sformatf("r%0d_peak", r), 32'(pkm), v.ep);
        chk($sformatf("r%0d_done", r), 32'(done), 1);
        chk($sformatf("r%0d_busy_rep", r), 32'(busy), 1);
      end else if ((v.gap != 0 && c % 2 == 0) || idx >= v.pre + v.n) begin
        corr_valid = 0;
      end else begin
        corr_valid = 1;
        corr_mag = 16'((idx < v.pre) ? v.fill : v.mag[idx - v.pre]);
        idx++;
      end
    end
    if (!seen) chk($sformatf("r%0d_no_we0", r), 0, 1);
    @(negedge clk);
    start = 0;
    chk($sformatf("r%0d_we0_after", r), 32'(we0), 0);
    chk($sformatf("r%0d_busy_after", r), 32'(busy), 0);
  endtask

  initial begin
    int s1[8] = '{10, 20, 150, 180, 170, 160, 150, 140};
    vec_t v;
    int cnt_we;

    rst = 1; start = 0; corr_valid = 0; corr_mag = 0; thr = 100;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_we0", 32'(we0), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_peak", 32'(pkm), 0);

    //        th  pre fill n gap sa thc thv  ec  data     peak
    v = mk(100, 0, 0, 8, 0, -1, 0, 0, 8, 'h8003, 180); v.mag = s1; tbl.push_back(v);
    v = mk(100, 64, 50, 0, 0, -1, 0, 0, 65, 'h7FFF, 0); tbl.push_back(v);
    v = mk(100, 5, 100, 4, 0, -1, 0, 0, 10, 'h8005, 101);
    v.mag = '{101, 50, 50, 50, 0, 0, 0, 0}; tbl.push_back(v);
    v = mk(100, 0, 0, 6, 0, -1, 0, 0, 6, 'h8001, 200);
    v.mag = '{120, 200, 200, 199, 198, 197, 0, 0}; tbl.push_back(v);
    v = mk(100, 0, 0, 8, 1, -1, 0, 0, 14, 'h8003, 180); v.mag = s1; tbl.push_back(v);
    v = mk(100, 0, 0, 8, 0, 5, 0, 0, 8, 'h8003, 180); v.mag = s1; tbl.push_back(v);
    v = mk(100, 0, 0, 8, 0, 8, 0, 0, 8, 'h8003, 180); v.mag = s1; tbl.push_back(v);
    v = mk(100, 0, 0, 8, 0, -1, 2, 200, 8, 'h8003, 180); v.mag = s1; tbl.push_back(v);
    v = mk(100, 63, 50, 1, 0, -1, 0, 0, 65, 'h803F, 200);
    v.mag = '{200, 0, 0, 0, 0, 0, 0, 0}; tbl.push_back(v);
    v = mk(100, 61, 50, 3, 0, -1, 0, 0, 65, 'h803F, 200);
    v.mag = '{150, 140, 200, 0, 0, 0, 0, 0}; tbl.push_back(v);
    v = mk(100, 64, 100, 0, 0, -1, 0, 0, 65, 'h7FFF, 0); tbl.push_back(v);

    foreach (tbl[i]) run_row(tbl[i], i);

    // A start in the IDLE cycle right after REPORT must be accepted.
    run_row(tbl[0], 99);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("restart_busy", 32'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;

    // Reset while tracking a peak: no write, outputs cleared.
    thr = 100; start = 1;
    @(negedge clk);
    start = 0; corr_valid = 1; corr_mag = 150;
    @(negedge clk);
    corr_mag = 160;
    @(negedge clk);
    chk("trk_busy", 32'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_we0", 32'(we0), 0);
    chk("rst_mid_data", 32'(data), 0);
    chk("rst_mid_peak", 32'(pkm), 0);
    cnt_we = 0;
    corr_mag = 10;
    repeat (10) begin
      @(negedge clk);
      if (we0) cnt_we++;
    end
    corr_valid = 0;
    chk("rst_mid_no_write", cnt_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
